// File: rtl/tc_ppa_gnt_sink.sv
// tc_ppa_gnt_sink: grant-side consumer for the N-way arbiter.
// Each accepted one-hot grant is turned into an {index, payload} entry in a
// small FIFO. The FIFO drains through a valid/ready stream toward the shared
// resource.
// Optional feature: define TC_PPA_GNT_SINK_ONEHOT_CHK_EN to enable the sticky
// multi-hot grant error (err_o) and its simulation assertion. When the macro
// is undefined, err_o is tied low.
module tc_ppa_gnt_sink #(
    parameter int WIDTH_REQ = 8,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    localparam int IDX_W    = $clog2(WIDTH_REQ),
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int LVL_W    = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [WIDTH_REQ-1:0]        gnt_i,
    output logic                        gnt_rdy_o,
    input  logic [WIDTH_REQ*DATA_W-1:0] data_i,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [IDX_W-1:0]            m_idx_o,
    output logic [DATA_W-1:0]           m_data_o,
    output logic [LVL_W-1:0]            level_o,
    output logic                        err_o
);

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    logic [WIDTH_REQ-1:0] gnt_low;
    entry_t               push_ent;
    logic                 push;
    logic                 pop;

    // Ready and valid come only from the registered level, never from inputs.
    assign gnt_rdy_o = (level_q != LVL_W'(DEPTH));
    assign m_valid_o = (level_q != '0);
    assign level_o   = level_q;
    assign m_idx_o   = mem_q[rd_ptr_q].idx;
    assign m_data_o  = mem_q[rd_ptr_q].data;

    assign push = gnt_rdy_o & (|gnt_i);
    assign pop  = m_valid_o & m_ready_i;

    // Isolate the lowest set grant bit. A multi-hot grant still yields one winner.
    always_comb begin
        gnt_low = gnt_i & (~gnt_i + WIDTH_REQ'(1));
    end

    // Encode the isolated bit into an index and mux in its payload slice.
    always_comb begin
        push_ent = '0;
        for (int k = 0; k < WIDTH_REQ; k++) begin
            if (gnt_low[k]) begin
                push_ent.idx  = push_ent.idx | IDX_W'(k);
                push_ent.data = push_ent.data | data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_ent;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // FIFO state registers. Storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

`ifdef TC_PPA_GNT_SINK_ONEHOT_CHK_EN
    logic multi_hot;
    logic err_q, err_d;

    assign multi_hot = |(gnt_i & (gnt_i - WIDTH_REQ'(1)));
    assign err_o     = err_q;

    // Sticky error: set on any accepted grant carrying more than one bit.
    always_comb begin
        err_d = err_q | (push & multi_hot);
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    a_onehot_gnt : assert property (@(posedge clk) disable iff (!reset_n)
                                    !(push && multi_hot))
        else $warning("tc_ppa_gnt_sink: multi-hot grant accepted");
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tc_ppa_gnt_sink.sv
// Bench for tc_ppa_gnt_sink: queue-based reference model, random payloads.
module tb_tc_ppa_gnt_sink;
    localparam int WR = 8;
    localparam int DW = 32;
    localparam int DP = 4;
    localparam int IW = $clog2(WR);
    localparam int LW = $clog2(DP) + 1;

    logic              clk;
    logic              reset_n;
    logic [WR-1:0]     gnt_i;
    logic              gnt_rdy_o;
    logic [WR*DW-1:0]  data_i;
    logic              m_valid_o;
    logic              m_ready_i;
    logic [IW-1:0]     m_idx_o;
    logic [DW-1:0]     m_data_o;
    logic [LW-1:0]     level_o;
    logic              err_o;

    typedef struct {
        int          idx;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];
    bit   m_err;
    int   errors = 0;
    int   checks = 0;

    tc_ppa_gnt_sink #(.WIDTH_REQ(WR), .DATA_W(DW), .DEPTH(DP)) dut (
        .clk(clk), .reset_n(reset_n), .gnt_i(gnt_i), .gnt_rdy_o(gnt_rdy_o),
        .data_i(data_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_idx_o(m_idx_o), .m_data_o(m_data_o), .level_o(level_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic rand_data();
        for (int k = 0; k < WR; k++) data_i[k*DW +: DW] = $urandom();
    endtask

    // Advance one clock edge, applying the FIFO rules to the model.
    task automatic tick();
        bit   do_push, do_pop;
        ent_t e;
        do_push = (mq.size() != DP) && (gnt_i != '0);
        do_pop  = (mq.size() != 0) && m_ready_i;
        e.idx = 0;
        e.data = '0;
        if (do_push) begin
            for (int k = WR - 1; k >= 0; k--) if (gnt_i[k]) e.idx = k;
            e.data = data_i[e.idx*DW +: DW];
`ifdef TC_PPA_GNT_SINK_ONEHOT_CHK_EN
            if ($countones(gnt_i) > 1) m_err = 1'b1;
`endif
        end
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        checks += 6;
        if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", m_valid_o); end
        if (level_o !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level_o); end
        if (gnt_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%0b exp=1", gnt_rdy_o); end
        if (m_idx_o !== '0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", m_idx_o); end
        if (m_data_o !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", m_data_o); end
        if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", err_o); end
    endtask

    task automatic test_single();
        rand_data();
        data_i[2*DW +: DW] = 32'hA5A5_0002;
        gnt_i = 8'b0000_0100;
        m_ready_i = 1'b1;
        tick();
        gnt_i = '0;
        checks += 3;
        if (m_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", m_valid_o); end
        if (m_idx_o !== IW'(2)) begin errors++; $display("FAIL single_idx got=%0d exp=2", m_idx_o); end
        if (m_data_o !== 32'hA5A5_0002) begin errors++; $display("FAIL single_data got=%h exp=a5a50002", m_data_o); end
        tick();
        checks += 2;
        if (level_o !== '0) begin errors++; $display("FAIL single_level got=%0d exp=0", level_o); end
        if (m_valid_o !== 1'b0) begin errors++; $display("FAIL single_drain got=%0b exp=0", m_valid_o); end
    endtask

    task automatic test_fill_hold();
        int exp_order[5] = '{0, 1, 2, 3, 5};
        int n = 0;
        m_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gnt_i = WR'(1) << i;
            rand_data();
            tick();
        end
        gnt_i = WR'(1) << 5;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            checks += 2;
            if (level_o !== LW'(4)) begin errors++; $display("FAIL full_level got=%0d exp=4", level_o); end
            if (gnt_rdy_o !== 1'b0) begin errors++; $display("FAIL full_rdy got=%0b exp=0", gnt_rdy_o); end
            tick();
        end
        m_ready_i = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc == 2) gnt_i = '0;
            checks += 2;
            if (gnt_rdy_o !== (mq.size() != DP)) begin errors++; $display("FAIL drain_rdy cyc=%0d got=%0b exp=%0b", cyc, gnt_rdy_o, mq.size() != DP); end
            if (level_o !== LW'(mq.size())) begin errors++; $display("FAIL drain_level cyc=%0d got=%0d exp=%0d", cyc, level_o, mq.size()); end
            if (m_valid_o && n < 5) begin
                checks += 2;
                if (m_idx_o !== IW'(exp_order[n])) begin errors++; $display("FAIL drain_order n=%0d got=%0d exp=%0d", n, m_idx_o, exp_order[n]); end
                if (m_data_o !== mq[0].data) begin errors++; $display("FAIL drain_data n=%0d got=%h exp=%h", n, m_data_o, mq[0].data); end
                n++;
            end
            tick();
            if (cyc == 0) begin
                checks++;
                if (level_o !== LW'(3)) begin errors++; $display("FAIL full_pop_level got=%0d exp=3", level_o); end
            end
        end
        checks++;
        if (n !== 5) begin errors++; $display("FAIL drain_count got=%0d exp=5", n); end
    endtask

    task automatic test_stream();
        m_ready_i = 1'b1;
        for (int i = 0; i < 14; i++) begin
            gnt_i = WR'(1) << (7 - (i % 8));
            rand_data();
            tick();
            checks += 3;
            if (level_o !== LW'(1)) begin errors++; $display("FAIL stream_level i=%0d got=%0d exp=1", i, level_o); end
            if (m_idx_o !== IW'(mq[0].idx)) begin errors++; $display("FAIL stream_idx i=%0d got=%0d exp=%0d", i, m_idx_o, mq[0].idx); end
            if (m_data_o !== mq[0].data) begin errors++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, m_data_o, mq[0].data); end
        end
        gnt_i = '0;
        tick();
    endtask

    task automatic test_multi();
        m_ready_i = 1'b0;
        rand_data();
        gnt_i = 8'b0001_0010;
        tick();
        gnt_i = '0;
        checks += 3;
        if (m_idx_o !== IW'(1)) begin errors++; $display("FAIL multi_idx got=%0d exp=1", m_idx_o); end
        if (m_data_o !== mq[0].data) begin errors++; $display("FAIL multi_data got=%h exp=%h", m_data_o, mq[0].data); end
        if (err_o !== m_err) begin errors++; $display("FAIL multi_err got=%0b exp=%0b", err_o, m_err); end
        m_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (err_o !== m_err) begin errors++; $display("FAIL multi_sticky got=%0b exp=%0b", err_o, m_err); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            gnt_i = ($urandom_range(0, 3) == 0) ? '0 : (WR'(1) << $urandom_range(0, WR - 1));
            m_ready_i = ($urandom_range(0, 2) != 0);
            rand_data();
            checks += 4;
            if (m_valid_o !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid i=%0d got=%0b", i, m_valid_o); end
            if (level_o !== LW'(mq.size())) begin errors++; $display("FAIL rnd_level i=%0d got=%0d exp=%0d", i, level_o, mq.size()); end
            if (gnt_rdy_o !== (mq.size() != DP)) begin errors++; $display("FAIL rnd_rdy i=%0d got=%0b", i, gnt_rdy_o); end
            if (err_o !== m_err) begin errors++; $display("FAIL rnd_err i=%0d got=%0b exp=%0b", i, err_o, m_err); end
            if (mq.size() != 0) begin
                checks += 2;
                if (m_idx_o !== IW'(mq[0].idx)) begin errors++; $display("FAIL rnd_idx i=%0d got=%0d exp=%0d", i, m_idx_o, mq[0].idx); end
                if (m_data_o !== mq[0].data) begin errors++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, m_data_o, mq[0].data); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        while (mq.size() != 0) begin
            gnt_i = '0;
            m_ready_i = 1'b1;
            tick();
        end
        m_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gnt_i = WR'(1) << (i + 4);
            rand_data();
            tick();
        end
        gnt_i = '0;
        checks++;
        if (level_o !== LW'(3)) begin errors++; $display("FAIL pre_reset_level got=%0d exp=3", level_o); end
        reset_n = 1'b0;
        #1;
        mq.delete();
        m_err = 1'b0;
        checks += 4;
        if (m_valid_o !== 1'b0) begin errors++; $display("FAIL async_valid got=%0b exp=0", m_valid_o); end
        if (level_o !== '0) begin errors++; $display("FAIL async_level got=%0d exp=0", level_o); end
        if (gnt_rdy_o !== 1'b1) begin errors++; $display("FAIL async_rdy got=%0b exp=1", gnt_rdy_o); end
        if (err_o !== 1'b0) begin errors++; $display("FAIL async_err got=%0b exp=0", err_o); end
        #2;
        reset_n = 1'b1;
        m_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (m_valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_valid i=%0d got=%0b exp=0", i, m_valid_o); end
        end
        rand_data();
        gnt_i = WR'(1) << 6;
        tick();
        gnt_i = '0;
        checks += 2;
        if (m_idx_o !== IW'(6)) begin errors++; $display("FAIL post_reset_idx got=%0d exp=6", m_idx_o); end
        if (m_data_o !== mq[0].data) begin errors++; $display("FAIL post_reset_data got=%h exp=%h", m_data_o, mq[0].data); end
    endtask

    initial begin
        reset_n = 1'b0;
        gnt_i = '0;
        data_i = '0;
        m_ready_i = 1'b0;
        m_err = 1'b0;
        #12;
        reset_n = 1'b1;
        test_reset();
        test_single();
        test_fill_hold();
        test_stream();
        test_multi();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
